// File: rtl/spi_pkg.sv
// Shared frame constants and FSM state type for the SPI memory responder.
package spi_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 16;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned FRAME_BITS = 40;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_mem_array.sv
// Word array with an asynchronous read port and a single synchronous write port.
module spi_mem_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 responder serving 40-bit read/write frames from an internal word memory,
// with a backdoor write port for preloading images.
module spi_slave_mem
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 sclk_i,
    input  logic                 csb_i,
    input  logic                 si_i,
    output logic                 so_o,
    input  logic                 bd_we_i,
    input  logic [ADDR_W-1:0]    bd_addr_i,
    input  logic [DATA_BITS-1:0] bd_data_i,
    output logic                 wr_o,
    output logic                 busy_o
);

    localparam logic [5:0] CntCmdLast  = 6'(CMD_BITS - 1);
    localparam logic [5:0] CntAddrLast = 6'(CMD_BITS + ADDR_BITS - 1);
    localparam logic [5:0] CntDataLast = 6'(FRAME_BITS - 1);
    localparam logic [5:0] CntSat      = 6'(FRAME_BITS);

    spi_state_e           state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 sclk_q;
    logic [DATA_BITS-1:0] rx_q, rx_d, rx_next;
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 is_rd_q, is_rd_d;
    logic                 so_q, so_d;
    logic                 wr_q, wr_d;

    logic                 rise, fall;
    logic                 commit;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    assign rise    = ~csb_i & sclk_i & ~sclk_q;
    assign fall    = ~csb_i & ~sclk_i & sclk_q;
    assign rx_next = {rx_q[DATA_BITS-2:0], si_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        is_rd_d = is_rd_q;
        so_d    = so_q;
        wr_d    = 1'b0;
        commit  = 1'b0;

        if (rise) begin
            rx_d = rx_next;
            if (cnt_q < CntSat) begin
                cnt_d = cnt_q + 6'd1;
            end
        end

        if (csb_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            so_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: begin
                    if (rise && cnt_q == CntCmdLast) begin
                        if (rx_next[7:0] == CMD_READ) begin
                            is_rd_d = 1'b1;
                            state_d = ADDR;
                        end else if (rx_next[7:0] == CMD_WRITE) begin
                            is_rd_d = 1'b0;
                            state_d = ADDR;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    // The read port is addressed by rx_next so the word is fetched on rise 24.
                    if (rise && cnt_q == CntAddrLast) begin
                        addr_d = rx_next[ADDR_W-1:0];
                        if (is_rd_q) begin
                            tx_d    = mem_rdata;
                            state_d = RD;
                        end else begin
                            state_d = WR;
                        end
                    end
                end
                RD: begin
                    // The fall after rise 40 ends the 16th bit window.
                    if (fall) begin
                        if (cnt_q == CntSat) begin
                            so_d    = 1'b0;
                            state_d = IGNORE;
                        end else begin
                            so_d = tx_q[DATA_BITS-1];
                            tx_d = {tx_q[DATA_BITS-2:0], 1'b0};
                        end
                    end
                end
                WR: begin
                    if (rise && cnt_q == CntDataLast) begin
                        commit  = 1'b1;
                        wr_d    = 1'b1;
                        state_d = IGNORE;
                    end
                end
                IGNORE: begin
                    so_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            is_rd_q <= 1'b0;
            so_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_i;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            is_rd_q <= is_rd_d;
            so_q    <= so_d;
            wr_q    <= wr_d;
        end
    end

    // An SPI commit takes the write port over a simultaneous backdoor write.
    assign mem_we    = commit | bd_we_i;
    assign mem_waddr = commit ? addr_q : bd_addr_i;
    assign mem_wdata = commit ? rx_next : bd_data_i;

    spi_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_BITS)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rx_next[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    assign so_o   = so_q;
    assign wr_o   = wr_q;
    assign busy_o = ~csb_i & (state_q != IDLE);

endmodule

// File: doc/spi_slave_mem.md
# spi_slave_mem

SPI responder that terminates the CPU's SPI memory bus: decodes read/write frames from the SPI master and serves them from an internal 16-bit word memory. Used as the memory-side model in system simulation and as an on-chip SPI RAM in FPGA builds. Frames are 40 bits: 8-bit command, 16-bit address, 16-bit data, MSB first, SPI mode 0. A backdoor write port preloads program and data images before the CPU runs.

## Interface
- ADDR_W, 10: memory depth is 2**ADDR_W 16-bit words; the frame address is used modulo the depth (low ADDR_W bits).
- clk  input  1  single clock; all logic on the rising edge.
- resetb  input  1  synchronous, active-low reset.
- sclk_i  input  1  SPI clock from the master; synchronous to clk, no synchronizer.
- csb_i  input  1  chip select, active low.
- si_i  input  1  MOSI, the master's serial output.
- so_o  output  1  MISO; registered; 0 whenever not shifting read data.
- bd_we_i  input  1  backdoor write enable.
- bd_addr_i  input  ADDR_W  backdoor address.
- bd_data_i  input  16  backdoor write data.
- wr_o  output  1  one-cycle pulse when an SPI write commits.
- busy_o  output  1  high while csb_i is low and state is not IDLE.

## Operation
- Edge detect: sclk_r <= sclk_i. Rise = sclk_i & ~sclk_r; fall = ~sclk_i & sclk_r. The detect is qualified by csb_i low.
- Bit counter cnt, 6 bits, cleared in IDLE. It increments on each qualified rise and saturates at 40.
- On each rise, si_i is sampled into the receive shift register.
- States:
  - IDLE: entered on reset or csb_i high. Goes to CMD on csb_i low.
  - CMD: after the 8th rise, 0x03 goes to ADDR with a read flag, 0x02 goes to ADDR with a write flag, and any other value goes to IGNORE.
  - ADDR: on the 24th rise, the address is complete.
    - Read: in the same cycle, tx_sr is loaded from mem[addr], using the completed address including the current si_i bit. Go to RD.
    - Write: go to WR.
  - RD: on each fall, so_o <= tx_sr[15] and tx_sr shifts left. After 16 bits are shifted out, go to IGNORE.
  - WR: on the 40th rise, mem[addr] <= received 16-bit word, wr_o pulses in the next cycle, and the state goes to IGNORE.
  - IGNORE: stays until csb_i goes high. so_o is 0.
- csb_i high in any state returns to IDLE on the next clk and clears cnt and so_o. A write aborted before the 40th rise never commits.
- Bits after bit 40 are ignored.
- Backdoor: when bd_we_i is high, mem[bd_addr_i] <= bd_data_i. If it coincides with an SPI write commit, the SPI write wins.
- Reset clears the state to IDLE, cnt to 0, and so_o, wr_o and busy_o to 0. Memory contents are not reset.

## Timing
- The master must hold sclk_i high and low for at least 1 clk each, so the edge detect sees every transition.
- Read latency: the first data bit is on so_o 1 clk after the fall that follows rise 24. It is stable before rise 25.
- Data bit k (0..15, MSB first) is valid from the fall after rise 24+k until the next fall.
- The write commits in the clk of rise 40. wr_o is high in the following clk. A read of the same address in a later frame returns the new value.
- Reset mid-frame: the block is idle 1 clk after resetb goes low. A frame in progress is lost and the master must reassert csb_i.

## Structure
- spi_pkg holds:
  - CMD_READ = 8'h03 and CMD_WRITE = 8'h02
  - CMD_BITS = 8, ADDR_BITS = 16, DATA_BITS = 16, FRAME_BITS = 40
  - the state enum {IDLE, CMD, ADDR, RD, WR, IGNORE}
- Sub-module spi_mem_array holds the word array:
  - asynchronous read port
  - one write port, with the SPI/backdoor priority mux inside the parent
- The top holds the edge detect, counter, FSM and shift registers.

## Test plan
- Write then read: frame 0x02 / 0x0005 / 0xBEEF, then frame 0x03 / 0x0005. Required: wr_o pulses once; so_o presents 1011111011101111 on the 16 falls after rise 24.
- Backdoor preload: bd write 0x1234 to address 7, then SPI read of 0x0007. Required: so_o serializes 0x1234; wr_o stays 0.
- Abort: write frame 0x02 / 0x0003 / 0xAAAA with csb_i raised after rise 32, then read address 3. Required: the old value is returned and wr_o never pulses.
- Illegal command 0xFF followed by 32 bits. Required: so_o is 0 throughout and memory is unchanged.
- Address wrap (ADDR_W=10): write 0x5A5A to 0x0405, then read 0x0005. Required: 0x5A5A.
- Reset mid-read: resetb low at rise 28. Required: so_o = 0 and busy_o = 0 on the next clk. A following full read frame returns correct data.
